dac_serializer: RTL and testbench

- Transmit-side counterpart of the ADC capture path. Takes 12-bit parallel samples from the equalizer datapath and shifts them out serially to an SPI-style 12-bit DAC (DAC121S101-class frame: 16 bits, MSB first, framed by SYNC).
- Generates SCLK and SYNC, and provides a one-deep holding register so the datapath can present a new sample while the current frame is still shifting.

---
 rtl/dac_serializer.sv | 109 ++++++++++
 tb/tb_dac_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serializer.sv
// Serializer for a 16-bit SPI-style DAC frame {2'b00, PD_MODE, dd}, sent MSB first.
// One-deep holding register accepts the next sample while a frame is shifting.
module dac_serializer #(
  parameter int         CLK_DIV = 2,
  parameter logic [1:0] PD_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] dd,
  output logic        sclk,
  output logic        sync_n,
  output logic        sdata,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, nxt;
  logic [DW-1:0] divcnt;
  logic [4:0]    half;
  logic [15:0]   shreg;
  logic [11:0]   hold;
  logic          hold_v;
  logic          tick, last, load;
  logic [11:0]   load_dd;

  assign tick = (divcnt == DW'(CLK_DIV - 1));
  assign last = tick && (half == 5'd31);

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    load_dd = dd;
    case (state)
      IDLE: if (enable) begin
        load = 1'b1;
        nxt  = SHIFT;
      end
      SHIFT: if (last) nxt = DONE;
      DONE: begin
        // a fresh strobe in the DONE cycle beats the held word
        if (enable) begin
          load = 1'b1;
          nxt  = SHIFT;
        end else if (hold_v) begin
          load    = 1'b1;
          load_dd = hold;
          nxt     = SHIFT;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      divcnt  <= '0;
      half    <= '0;
      shreg   <= '0;
      sclk    <= 1'b1;
      hold    <= '0;
      hold_v  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= nxt;
      overrun <= 1'b0;
      if (load) begin
        shreg  <= {2'b00, PD_MODE, load_dd};
        divcnt <= '0;
        half   <= '0;
        sclk   <= 1'b1;
      end else if (state == SHIFT) begin
        if (tick) begin
          divcnt <= '0;
          if (last) begin
            sclk <= 1'b1;
          end else begin
            half <= half + 5'd1;
            sclk <= ~sclk;
            // advance data on the rising sclk so it is stable across the fall
            if (!sclk) shreg <= {shreg[14:0], 1'b0};
          end
        end else begin
          divcnt <= divcnt + DW'(1);
        end
      end

      if (state == SHIFT && enable) begin
        hold    <= dd;
        hold_v  <= 1'b1;
        overrun <= hold_v;
      end else if (state == DONE && !enable && hold_v) begin
        hold_v <= 1'b0;
      end
    end
  end

  assign sync_n = (state != SHIFT);
  assign sdata  = (state == SHIFT) && shreg[15];
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench: stimulus pushes expected frame words, a monitor decodes
// frames off sclk falls and compares them in order.
module tb_dac_serializer;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] dd = '0;
  logic        sclk, sync_n, sdata, busy, done, overrun;

  dac_serializer #(.CLK_DIV(CD), .PD_MODE(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dd(dd),
    .sclk(sclk), .sync_n(sync_n), .sdata(sdata),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          ov_cnt = 0;
  logic [15:0] expq[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // frame monitor
  logic        prev_sclk = 1'b1;
  bit          in_fr = 1'b0;
  logic [15:0] bits;
  int          nb, low;

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (!rst_n) begin
      if (in_fr) begin
        if (expq.size() > 0) void'(expq.pop_front());
        in_fr = 1'b0;
      end
    end else if (!sync_n) begin
      if (!in_fr) begin
        in_fr = 1'b1;
        bits  = '0;
        nb    = 0;
        low   = 0;
      end
      low++;
      if (prev_sclk && !sclk) begin
        bits = {bits[14:0], sdata};
        nb++;
      end
    end else if (in_fr) begin
      in_fr = 1'b0;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got %0h expected none", bits);
      end else begin
        chk("frame_word", int'(bits), int'(expq.pop_front()));
        chk("frame_bits", nb, 16);
        chk("frame_len", low, 32 * CD);
      end
    end
    prev_sclk = sclk;
  end

  task automatic send(input logic [11:0] v);
    @(posedge clk); #1;
    enable = 1'b1;
    dd     = v;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, dcount, dk, busy65, sclk_pre, sclk_fall, falls, ovbase, anybusy;
    logic ps;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({sclk, sync_n, sdata, busy, done, overrun}), 6'b110000);
    end

    // single frame, timing
    send(12'hA5C);
    expq.push_back(16'h0A5C);
    lowc = 0; dcount = 0; dk = -1; busy65 = -1; sclk_pre = -1; sclk_fall = -1;
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      if (k == 0) chk("first_cycle", int'({sync_n, sclk, busy}), 3'b011);
      if (!sync_n) lowc++;
      if (done) begin
        dcount++;
        dk = k;
      end
      if (k == CD - 1) sclk_pre = int'(sclk);
      if (k == CD) sclk_fall = int'(sclk);
      if (k == 65) busy65 = int'(busy);
    end
    chk("sync_low_cycles", lowc, 64);
    chk("done_count", dcount, 1);
    chk("done_latency", dk, 64);
    chk("busy_after_done", busy65, 0);
    chk("sclk_before_fall", sclk_pre, 1);
    chk("sclk_first_fall", sclk_fall, 0);

    // back-to-back via hold
    ovbase = ov_cnt;
    send(12'h001);
    expq.push_back(16'h0001);
    repeat (10) @(posedge clk);
    send(12'hFFF);
    expq.push_back(16'h0FFF);
    wait_done("b2b_done1");
    chk("b2b_sync_high_done", int'(sync_n), 1);
    @(negedge clk);
    chk("b2b_gap_one", int'({sync_n, busy}), 2'b01);
    wait_done("b2b_done2");
    wait_idle("b2b_idle");
    chk("b2b_no_overrun", ov_cnt - ovbase, 0);

    // overrun
    ovbase = ov_cnt;
    send(12'h333);
    expq.push_back(16'h0333);
    repeat (10) @(posedge clk);
    send(12'h123);
    chk("ovr_first_write", int'(overrun), 0);
    repeat (5) @(posedge clk);
    send(12'h456);
    chk("ovr_second_write", int'(overrun), 1);
    expq.push_back(16'h0456);
    @(posedge clk); #1;
    chk("ovr_one_cycle", int'(overrun), 0);
    wait_idle("ovr_idle");
    chk("ovr_count", ov_cnt - ovbase, 1);

    // enable coincident with DONE
    send(12'h0AA);
    expq.push_back(16'h00AA);
    repeat (10) @(posedge clk);
    send(12'h111);
    wait_done("dc_done");
    enable = 1'b1;
    dd     = 12'h222;
    @(posedge clk); #1;
    enable = 1'b0;
    expq.push_back(16'h0222);
    expq.push_back(16'h0111);
    wait_idle("dc_idle");

    // reset mid-frame at the 8th fall
    send(12'h555);
    expq.push_back(16'h0555);
    repeat (4) @(posedge clk);
    send(12'h777);
    falls = 0;
    ps = sclk;
    for (int i = 0; i < 400 && falls < 8; i++) begin
      @(negedge clk);
      if (ps && !sclk) falls++;
      ps = sclk;
    end
    chk("rst_reach_fall8", falls, 8);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_outputs", int'({sclk, sync_n, sdata, busy, done, overrun}), 6'b110000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    send(12'h800);
    expq.push_back(16'h0800);
    wait_idle("rst_new_idle");
    anybusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) anybusy = 1;
    end
    chk("rst_hold_empty", anybusy, 0);
    chk("queue_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
